// File: rtl/l2_port_arbiter_pkg.sv
// Shared processor types used by the L2 port arbiter: FSM states, grant source
// and line geometry.
package rv32i_types;

    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE
    } arb_state_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } arb_src_t;

endpackage

// File: rtl/l2_port_arbiter_if.sv
// Bundle of I-cache, D-cache and L2 line-port signals around the arbiter.
// master is the arbiter's view; slave is the caches/L2 side.
interface l2_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;

    modport master (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
               l2_rdata, l2_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               l2_read, l2_write, l2_address, l2_wdata
    );

    modport slave (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
               l2_rdata, l2_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               l2_read, l2_write, l2_address, l2_wdata
    );
endinterface

// File: rtl/l2_port_arbiter_req_latch.sv
// Registered copy of the granted request (line address, write data, op) that
// drives the L2 port for the whole transaction.
module arb_req_latch
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] next_address,
    input  logic [DATA_W-1:0] next_wdata,
    input  logic              next_write,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wdata,
    output logic              op_write
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address  <= '0;
            wdata    <= '0;
            op_write <= 1'b0;
        end else if (load) begin
            address  <= next_address;
            wdata    <= next_wdata;
            op_write <= next_write;
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Arbitrates the shared L2 line port between the I-cache and D-cache miss paths
// and counts cycles where both sides were waiting to be granted.
module l2_port_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = rv32i_types::LINE_W,
    parameter int OFFSET_W = rv32i_types::OFFSET_W
) (
    input  logic                clk,
    input  logic                rst_n,
    l2_port_arbiter_if.master   bus,
    input  logic                clear_conflicts,
    output logic [31:0]         conflict_count
);

    localparam logic [ADDR_W-1:0] LINE_MASK =
        {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    arb_state_t        state_q, state_d;
    arb_src_t          last_grant_q;
    logic [31:0]       conflict_q;
    logic              req_i, req_d, both_req;
    logic              load, sel_d;
    logic              op_write, busy, i_resp, d_resp;
    logic [ADDR_W-1:0] sel_address;
    logic [LINE_W-1:0] sel_wdata;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign req_i    = bus.i_read;
    assign req_d    = bus.d_read | bus.d_write;
    assign both_req = req_i & req_d;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        sel_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time goes next.
                if (req_d && (!req_i || last_grant_q == SRC_I)) begin
                    sel_d   = 1'b1;
                    load    = 1'b1;
                    state_d = BUSY_D;
                end else if (req_i) begin
                    load    = 1'b1;
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: if (bus.l2_resp) state_d = DONE;
            DONE:           state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_I;
            conflict_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) last_grant_q <= sel_d ? SRC_D : SRC_I;
            if (clear_conflicts)
                conflict_q <= '0;
            else if (state_q == IDLE && both_req)
                conflict_q <= sat_inc(conflict_q);
        end
    end

    // A D write wins over a simultaneous D read, so only d_write sets the op.
    assign sel_address = (sel_d ? bus.d_address : bus.i_address) & LINE_MASK;
    assign sel_wdata   = sel_d ? bus.d_wdata : '0;

    arb_req_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (LINE_W)
    ) u_req_latch (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .next_address (sel_address),
        .next_wdata   (sel_wdata),
        .next_write   (sel_d & bus.d_write),
        .address      (bus.l2_address),
        .wdata        (bus.l2_wdata),
        .op_write     (op_write)
    );

    // ---- L2 strobes and response routing, all decoded from registered state
    assign busy         = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign bus.l2_read  = busy & ~op_write;
    assign bus.l2_write = busy & op_write;

    assign i_resp      = (state_q == BUSY_I) & bus.l2_resp;
    assign d_resp      = (state_q == BUSY_D) & bus.l2_resp;
    assign bus.i_resp  = i_resp;
    assign bus.d_resp  = d_resp;
    assign bus.i_rdata = i_resp ? bus.l2_rdata : '0;
    assign bus.d_rdata = d_resp ? bus.l2_rdata : '0;

    assign conflict_count = conflict_q;

endmodule
